// File: rtl/qpsk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qpsk_pkg                                                                    |
// | Types and defaults shared by the QPSK packet reader and symbol streamer.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package qpsk_pkg;

  localparam int BRAM_BITDEPTH_DEFAULT = 16;
  localparam int BRAM_BITWIDTH_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    COLLECT = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } streamer_state_e;

  function automatic int symbols_per_word(input int data_w, input int sym_w);
    return data_w / sym_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_symbol_streamer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_symbol_streamer_if                                                     |
// | AXI-Stream bundle carrying packed symbol words to the DMA.                  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface bram_symbol_streamer_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tstrb;

  modport master (output tvalid, output tlast, output tdata, output tstrb, input tready);
  modport slave  (input tvalid, input tlast, input tdata, input tstrb, output tready);
endinterface
`default_nettype wire

// File: rtl/bram_read_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_read_tag_pipe                                                          |
// | Delay line of {valid, slot} matching the BRAM read latency.                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module bram_read_tag_pipe #(
  parameter int DEPTH  = 2,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [SLOT_W-1:0] slot_i,
  output logic              valid_o,
  output logic [SLOT_W-1:0] slot_o
);
  logic [DEPTH-1:0]  valid_q;
  logic [SLOT_W-1:0] slot_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      slot_q[0]  <= slot_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        slot_q[i]  <= slot_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign slot_o  = slot_q[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/bram_symbol_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_symbol_streamer                                                        |
// | Reads a frame of 2-bit symbols from BRAM, packs them LSB-first, streams.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module bram_symbol_streamer
  import qpsk_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_BITDEPTH          = BRAM_BITDEPTH_DEFAULT,
  parameter int BRAM_BITWIDTH          = BRAM_BITWIDTH_DEFAULT,
  parameter int READ_LATENCY           = 2
) (
  input  logic                     m00_axis_aclk,
  input  logic                     m00_axis_areset,
  input  logic                     start,
  input  logic [BRAM_BITDEPTH:0]   num_symbols,
  output logic                     busy,
  output logic                     done,
  output logic [BRAM_BITDEPTH-1:0] bram_addr,
  output logic                     bram_en,
  input  logic [BRAM_BITWIDTH-1:0] bram_doutb,
  bram_symbol_streamer_if.master   m00_axis
);
  localparam int SPW    = symbols_per_word(C_M00_AXIS_TDATA_WIDTH, BRAM_BITWIDTH);
  localparam int SLOT_W = $clog2(SPW);
  localparam int CNT_W  = SLOT_W + 1;
  localparam int REM_W  = BRAM_BITDEPTH + 1;
  localparam logic [REM_W-1:0] SPW_REM = REM_W'(SPW);
  localparam logic [CNT_W-1:0] SPW_CNT = CNT_W'(SPW);

  streamer_state_e                   state_q;
  logic [REM_W-1:0]                  rem_q;
  logic [BRAM_BITDEPTH-1:0]          addr_cnt_q;
  logic [CNT_W-1:0]                  n_q, issued_q, cap_q;
  logic [SLOT_W-1:0]                 slot_q;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] pack_q, tdata_q;
  logic                              tvalid_q, tlast_q, busy_q, done_q, bram_en_q;
  logic [BRAM_BITDEPTH-1:0]          bram_addr_q;
  logic [CNT_W-1:0]                  first_n_d, next_n_d;
  logic                              ret_valid;
  logic [SLOT_W-1:0]                 ret_slot;

  assign first_n_d = (num_symbols >= SPW_REM) ? SPW_CNT : num_symbols[CNT_W-1:0];
  assign next_n_d  = (rem_q >= SPW_REM) ? SPW_CNT : rem_q[CNT_W-1:0];

  bram_read_tag_pipe #(
    .DEPTH  (READ_LATENCY),
    .SLOT_W (SLOT_W)
  ) u_tag_pipe (
    .clk     (m00_axis_aclk),
    .rst     (m00_axis_areset),
    .valid_i (bram_en_q),
    .slot_i  (slot_q),
    .valid_o (ret_valid),
    .slot_o  (ret_slot)
  );

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      addr_cnt_q  <= '0;
      n_q         <= '0;
      issued_q    <= '0;
      cap_q       <= '0;
      slot_q      <= '0;
      pack_q      <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
    end else begin
      // Only tagged returns reach the pack register; untagged read data is ignored.
      if (ret_valid) begin
        pack_q[int'(ret_slot)*BRAM_BITWIDTH +: BRAM_BITWIDTH] <= bram_doutb;
        cap_q <= cap_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            pack_q <= '0;
            cap_q  <= '0;
            if (num_symbols == '0) begin
              rem_q   <= '0;
              state_q <= DONE;
            end else begin
              // First read goes out on the accepting edge itself.
              n_q         <= first_n_d;
              bram_en_q   <= 1'b1;
              bram_addr_q <= '0;
              addr_cnt_q  <= BRAM_BITDEPTH'(1);
              slot_q      <= '0;
              issued_q    <= CNT_W'(1);
              rem_q       <= num_symbols - REM_W'(1);
              state_q     <= FETCH;
            end
          end
        end
        FETCH: begin
          if (issued_q < n_q) begin
            bram_en_q   <= 1'b1;
            bram_addr_q <= addr_cnt_q;
            addr_cnt_q  <= addr_cnt_q + BRAM_BITDEPTH'(1);
            slot_q      <= issued_q[SLOT_W-1:0];
            issued_q    <= issued_q + CNT_W'(1);
            rem_q       <= rem_q - REM_W'(1);
          end else begin
            bram_en_q <= 1'b0;
            state_q   <= COLLECT;
          end
        end
        COLLECT: begin
          if (cap_q == n_q) begin
            tdata_q  <= pack_q;
            tvalid_q <= 1'b1;
            tlast_q  <= (rem_q == '0);
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (m00_axis.tready) begin
            tvalid_q <= 1'b0;
            if (tlast_q) begin
              tlast_q <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              pack_q   <= '0;
              cap_q    <= '0;
              issued_q <= '0;
              n_q      <= next_n_d;
              state_q  <= FETCH;
            end
          end
        end
        DONE: begin
          // An empty frame arrives here with done still low; a streamed frame with it already high.
          done_q  <= ~done_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign bram_en          = bram_en_q;
  assign bram_addr        = bram_addr_q;
  assign m00_axis.tvalid  = tvalid_q;
  assign m00_axis.tlast   = tlast_q;
  assign m00_axis.tdata   = tdata_q;
  assign m00_axis.tstrb   = '1;
endmodule
`default_nettype wire

// File: tb/tb_bram_symbol_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bram_symbol_streamer                                                     |
// | Random-stimulus bench with a frame-level reference model of the streamer.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bram_symbol_streamer;
  localparam int DW  = 32;
  localparam int BD  = 16;
  localparam int BW  = 2;
  localparam int RL  = 2;
  localparam int SPW = DW / BW;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    int            nsym;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [BD:0]   num = '0;
  logic          busy, done, bram_en;
  logic [BD-1:0] bram_addr;
  logic [BW-1:0] bram_doutb;

  bram_symbol_streamer_if #(.DATA_W(DW)) axis ();

  bram_symbol_streamer #(
    .C_M00_AXIS_TDATA_WIDTH (DW),
    .BRAM_BITDEPTH          (BD),
    .BRAM_BITWIDTH          (BW),
    .READ_LATENCY           (RL)
  ) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (rst),
    .start           (start),
    .num_symbols     (num),
    .busy            (busy),
    .done            (done),
    .bram_addr       (bram_addr),
    .bram_en         (bram_en),
    .bram_doutb      (bram_doutb),
    .m00_axis        (axis)
  );

  always #5 clk = ~clk;

  // BRAM port B model; cycles without a read return junk.
  logic [BW-1:0] mem [0:65535];
  logic [BW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= bram_en ? mem[bram_addr] : BW'($urandom);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_doutb = rd_pipe[RL-1];

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  word_t        exp_q[$];
  logic [DW:0]  seen[$];

  function automatic void build_frame(input int n);
    int nw;
    nw = (n + SPW - 1) / SPW;
    for (int w = 0; w < nw; w++) begin
      word_t e;
      e.nsym = ((n - w*SPW) < SPW) ? (n - w*SPW) : SPW;
      e.data = '0;
      for (int k = 0; k < e.nsym; k++) e.data[BW*k +: BW] = mem[(w*SPW + k) % 65536];
      e.last = (w == nw - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Cycle-level monitor and reference model.
  bit            frame_active;
  longint        exp_done_cyc;
  int            rem_en, next_addr, word_en;
  longint        word_first_en;
  bit            prev_stall, prev_tvalid, prev_last;
  logic [DW-1:0] prev_data;

  initial begin
    bit exp_done;
    frame_active = 0; exp_done_cyc = -1; rem_en = 0; next_addr = 0;
    word_en = 0; word_first_en = -1; prev_stall = 0; prev_tvalid = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        frame_active = 0; exp_q.delete(); exp_done_cyc = -1; rem_en = 0;
        word_en = 0; word_first_en = -1; prev_stall = 0; prev_tvalid = 0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", bram_en, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tlast", axis.tlast, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_tstrb", axis.tstrb, 4'hF);
      end else begin
        exp_done = (cyc == exp_done_cyc);
        check("done", done, exp_done);
        check("busy", busy, frame_active && !exp_done);
        if (axis.tvalid) check("tstrb", axis.tstrb, 4'hF);
        if (prev_stall) begin
          check("stall_tvalid", axis.tvalid, 1);
          check("stall_tdata", axis.tdata, prev_data);
          check("stall_tlast", axis.tlast, prev_last);
        end
        if (rem_en == 0) check("bram_en_unexpected", bram_en, 0);
        else if (bram_en) begin
          check("en_during_tvalid", axis.tvalid, 0);
          check("bram_addr", bram_addr, next_addr);
          next_addr = (next_addr + 1) % 65536;
          rem_en--;
          word_en++;
          if (word_first_en < 0) word_first_en = cyc;
        end
        if (axis.tvalid && !prev_tvalid) begin
          check("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check("tvalid_latency", cyc - word_first_en, exp_q[0].nsym + RL + 1);
            check("word_reads", word_en, exp_q[0].nsym);
          end
          word_first_en = -1;
          word_en = 0;
        end
        if (axis.tvalid && axis.tready && exp_q.size() != 0) begin
          check("tdata", axis.tdata, exp_q[0].data);
          check("tlast", axis.tlast, exp_q[0].last);
          seen.push_back({axis.tlast, axis.tdata});
          if (exp_q[0].last) exp_done_cyc = cyc + 1;
          void'(exp_q.pop_front());
        end
        if (exp_done) begin
          check("reads_left", rem_en, 0);
          check("words_left", exp_q.size(), 0);
          frame_active = 0;
        end
        if (start && !frame_active) begin
          frame_active = 1;
          exp_q.delete();
          build_frame(int'(num));
          rem_en = int'(num);
          next_addr = 0;
          word_en = 0;
          word_first_en = -1;
          if (num == 0) exp_done_cyc = cyc + 2;
        end
        prev_stall  = axis.tvalid && !axis.tready;
        prev_tvalid = axis.tvalid;
        prev_data   = axis.tdata;
        prev_last   = axis.tlast;
      end
    end
  end

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    num = (BD+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input int thr);
    int k = 0;
    while (!done && k < maxc) begin
      if (thr < 16) axis.tready = ($urandom_range(0, 15) < thr);
      @(posedge clk); #1;
      k++;
    end
    check("frame_done", done, 1);
    axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc);
    int k = 0;
    while (!axis.tvalid && k < maxc) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_tvalid", axis.tvalid, 1);
  endtask

  task automatic run_frame(input int n, input int thr, input int maxc);
    seen.delete();
    pulse_start(n);
    wait_done(maxc, thr);
  endtask

  initial begin
    int lasts;
    axis.tready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = BW'(i % 4);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    run_frame(16, 16, 200);
    check("f16_words", seen.size(), 1);
    if (seen.size() >= 1) check("f16_word0", seen[0], {1'b1, 32'hE4E4E4E4});

    run_frame(20, 16, 200);
    check("f20_words", seen.size(), 2);
    if (seen.size() >= 2) begin
      check("f20_word0", seen[0], {1'b0, 32'hE4E4E4E4});
      check("f20_word1", seen[1], {1'b1, 32'h000000E4});
    end

    run_frame(0, 16, 20);
    check("f0_words", seen.size(), 0);

    // Stall a word for ten cycles.
    seen.delete();
    axis.tready = 1'b0;
    pulse_start(32);
    wait_valid(100);
    repeat (10) @(posedge clk);
    #1 axis.tready = 1'b1;
    wait_done(200, 16);
    check("f32_words", seen.size(), 2);

    for (int i = 0; i < 65536; i++) mem[i] = BW'($urandom);
    run_frame(200, 8, 2000);
    check("f200_words", seen.size(), 13);

    run_frame(65536, 15, 120000);
    check("full_words", seen.size(), 4096);
    lasts = 0;
    foreach (seen[i]) lasts += int'(seen[i][DW]);
    check("full_tlast_count", lasts, 1);
    if (seen.size() != 0) check("full_tlast_final", seen[seen.size()-1][DW], 1);

    // Second start while busy must not disturb the frame.
    seen.delete();
    pulse_start(40);
    repeat (5) @(posedge clk);
    #1 num = (BD+1)'(100);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400, 16);
    check("mid_words", seen.size(), 3);
    if (seen.size() >= 3) begin
      check("mid_last0", seen[0][DW], 0);
      check("mid_last1", seen[1][DW], 0);
      check("mid_last2", seen[2][DW], 1);
    end

    // Reset while word 2 of 4 is waiting for tready.
    for (int i = 0; i < 65536; i++) mem[i] = BW'(i % 4);
    seen.delete();
    axis.tready = 1'b0;
    pulse_start(64);
    wait_valid(100);
    axis.tready = 1'b1;
    @(posedge clk); #1 axis.tready = 1'b0;
    wait_valid(100);
    check("rst_case_words", seen.size(), 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("async_tvalid_drop", axis.tvalid, 0);
    check("async_busy_drop", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    axis.tready = 1'b1;
    run_frame(16, 16, 200);
    check("post_rst_words", seen.size(), 1);
    if (seen.size() >= 1) check("post_rst_word0", seen[0], {1'b1, 32'hE4E4E4E4});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
